wrr_arbiter: RTL and testbench

- Parametrised weighted round-robin arbiter; successor to the fixed 4-requester round-robin arbiter.
- Scales to N_REQ requesters.
- Each requester can hold the grant for a programmable burst of up to 2^WGT_W-1 consecutive service cycles.
- Sits between multiple initiators and one shared resource (bus port, FIFO write side); grant is registered and one-hot.

---
 rtl/wrr_arbiter_if.sv | 25 ++
 rtl/wrr_arbiter.sv | 126 ++++++++++++
 tb/tb_wrr_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle shared by the initiators and the weighted round-robin arbiter.
interface wrr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WGT_W = 4
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*WGT_W-1:0] weight_i;
  logic [N_REQ-1:0]       gnt_o;
  logic [IDX_W-1:0]       gnt_idx_o;
  logic                   gnt_valid_o;

  // Initiator side drives requests and weights, observes the grant
  modport master (
    output req_i, weight_i,
    input  gnt_o, gnt_idx_o, gnt_valid_o
  );

  // Arbiter side consumes requests and weights, produces the grant
  modport slave (
    input  req_i, weight_i,
    output gnt_o, gnt_idx_o, gnt_valid_o
  );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each winner keeps a registered one-hot grant
// for up to its weight in service cycles, then priority rotates past it.
module wrr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WGT_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  wrr_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WGT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;

  logic [IDX_W-1:0] scanStart;
  logic [IDX_W-1:0] winIdx;
  logic             winFound;
  logic             holderReq;

  // Modulo-N_REQ successor; explicit compare keeps non-power-of-2 sizes in range
  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(N_REQ - 1)) begin
      return '0;
    end
    return idx + IDX_W'(1);
  endfunction

  // Burst length for a requester; a zero weight still earns one cycle
  function automatic logic [WGT_W-1:0] effWgt(input logic [N_REQ*WGT_W-1:0] w,
                                              input logic [IDX_W-1:0] idx);
    logic [WGT_W-1:0] field;
    field = w[int'(idx)*WGT_W +: WGT_W];
    return (field == '0) ? WGT_W'(1) : field;
  endfunction

  assign holderReq = bus.req_i[idx_q];

  // Find the first active request scanning forward from the rotation start
  always_comb begin
    int cand;
    cand      = 0;
    scanStart = (state_q == GRANT) ? nextIdx(idx_q) : ptr_q;
    winFound  = 1'b0;
    winIdx    = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = int'(scanStart) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (bus.req_i[cand]) begin
        winFound = 1'b1;
        winIdx   = IDX_W'(cand);
      end
    end
  end

  // Next-state: hold the burst while served, otherwise rotate and re-arbitrate
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (winFound) begin
          state_d = GRANT;
          idx_d   = winIdx;
          cnt_d   = effWgt(bus.weight_i, winIdx);
        end
      end
      GRANT: begin
        if (holderReq && (cnt_q > WGT_W'(1))) begin
          cnt_d = cnt_q - WGT_W'(1);
        end else begin
          ptr_d = nextIdx(idx_q);
          if (winFound) begin
            idx_d = winIdx;
            cnt_d = effWgt(bus.weight_i, winIdx);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: one-hot grant and valid follow the next state
  always_comb begin
    gnt_d = '0;
    if (state_d == GRANT) begin
      gnt_d[idx_d] = 1'b1;
    end
    valid_d = (state_d == GRANT);
  end

  // State and output registers; reset clears the grant immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_idx_o   = idx_q;
  assign bus.gnt_valid_o = valid_q;
endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: a 4-requester and a 5-requester instance checked
// every cycle against an integer reference model, plus directed sequences.
module tb_wrr_arbiter;
  localparam int NA = 4;
  localparam int WA = 4;
  localparam int NB = 5;
  localparam int WB = 2;

  logic clk = 1'b0;
  logic resetA;
  logic resetB;

  always #5 clk = ~clk;

  wrr_arbiter_if #(.N_REQ(NA), .WGT_W(WA)) busA();
  wrr_arbiter_if #(.N_REQ(NB), .WGT_W(WB)) busB();

  wrr_arbiter #(.N_REQ(NA), .WGT_W(WA)) dutA (.clk(clk), .reset(resetA), .bus(busA.slave));
  wrr_arbiter #(.N_REQ(NB), .WGT_W(WB)) dutB (.clk(clk), .reset(resetB), .bus(busB.slave));

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: holder (-1 idle), remaining burst, rotation pointer, last index
  int holderA, remA, ptrA, lastA;
  int holderB, remB, ptrB, lastB;

  int seqT2 [7] = '{0, 0, 0, 1, 2, 2, 3};

  // One clock of the arbitration rules expressed over plain integers
  task automatic modelStep(input int n, input int wbits, input logic [7:0] req,
                           input logic [31:0] wgt, inout int holder, inout int rem,
                           inout int ptr, inout int last);
    int start;
    int w;
    int c;
    if (holder >= 0 && req[holder] && rem > 1) begin
      rem = rem - 1;
      return;
    end
    if (holder >= 0) ptr = (holder + 1) % n;
    start  = ptr;
    holder = -1;
    for (int off = 0; off < n; off++) begin
      c = (start + off) % n;
      if (holder < 0 && req[c]) begin
        holder = c;
        w      = int'((wgt >> (c * wbits)) & ((32'd1 << wbits) - 1));
        rem    = (w == 0) ? 1 : w;
        last   = c;
      end
    end
  endtask

  function automatic logic [7:0] expGnt(input int holder);
    return (holder < 0) ? 8'h00 : 8'(1 << holder);
  endfunction

  // Single compare point; every mismatch is counted and reported
  task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both instances against their models
  task automatic checkOutput();
    checkOne("A_gnt",   8'(busA.gnt_o),       expGnt(holderA));
    checkOne("A_valid", 8'(busA.gnt_valid_o), (holderA >= 0) ? 8'h01 : 8'h00);
    checkOne("A_idx",   8'(busA.gnt_idx_o),   8'(lastA));
    checkOne("B_gnt",   8'(busB.gnt_o),       expGnt(holderB));
    checkOne("B_valid", 8'(busB.gnt_valid_o), (holderB >= 0) ? 8'h01 : 8'h00);
    checkOne("B_idx",   8'(busB.gnt_idx_o),   8'(lastB));
  endtask

  // Advance the given number of clocks with the inputs currently driven
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      modelStep(NA, WA, 8'(busA.req_i), 32'(busA.weight_i), holderA, remA, ptrA, lastA);
      if (resetB) begin
        modelStep(NB, WB, 8'(busB.req_i), 32'(busB.weight_i), holderB, remB, ptrB, lastB);
      end
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  // Asynchronous reset pulse on selected instances, released at the falling edge
  task automatic resetDuts(input bit doA, input bit doB);
    if (doA) begin
      resetA = 1'b0;
      holderA = -1; remA = 0; ptrA = 0; lastA = 0;
    end
    if (doB) begin
      resetB = 1'b0;
      holderB = -1; remB = 0; ptrB = 0; lastB = 0;
    end
    #1;
    checkOutput();
    @(negedge clk);
    resetA = 1'b1;
    resetB = 1'b1;
  endtask

  initial begin
    busA.req_i = '0; busA.weight_i = '0;
    busB.req_i = '0; busB.weight_i = '0;
    resetA = 1'b1;
    resetB = 1'b1;
    #2;
    resetDuts(1'b1, 1'b1);

    $display("[TB] equal weights, all requesting");
    busA.weight_i = 16'h1111;
    busA.req_i    = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1);
      checkOne("t1_gnt", 8'(busA.gnt_o), 8'(1 << (i % 4)));
    end

    $display("[TB] weights 3,1,2,1");
    resetDuts(1'b1, 1'b0);
    busA.weight_i = 16'h1213;
    busA.req_i    = 4'b1111;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1);
      checkOne("t2_idx", 8'(busA.gnt_idx_o), 8'(seqT2[i % 7]));
    end

    $display("[TB] r2 drops request mid-burst");
    resetDuts(1'b1, 1'b0);
    busA.weight_i = 16'h1411;
    busA.req_i    = 4'b1111;
    applyStimulus(3);
    checkOne("t3_r2_first", 8'(busA.gnt_idx_o), 8'd2);
    busA.req_i = 4'b1011;
    applyStimulus(1);
    checkOne("t3_to_r3", 8'(busA.gnt_o), 8'b1000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      checkOne("t3_no_r2", 8'(busA.gnt_o[2]), 8'h00);
    end

    $display("[TB] lone requester");
    resetDuts(1'b1, 1'b0);
    busA.weight_i = 16'h1121;
    busA.req_i    = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      checkOne("t4_hold", 8'(busA.gnt_o), 8'b0010);
    end
    busA.req_i = 4'b0000;
    applyStimulus(1);
    checkOne("t4_gnt_off", 8'(busA.gnt_o), 8'h00);
    checkOne("t4_valid_off", 8'(busA.gnt_valid_o), 8'h00);

    $display("[TB] zero weight");
    resetDuts(1'b1, 1'b0);
    busA.weight_i = 16'h1110;
    busA.req_i    = 4'b0011;
    applyStimulus(1);
    checkOne("t5_r0", 8'(busA.gnt_o), 8'b0001);
    applyStimulus(1);
    checkOne("t5_r1", 8'(busA.gnt_o), 8'b0010);
    busA.req_i = 4'b0000;

    $display("[TB] five requesters, wrap-around");
    busB.weight_i = 10'h155;
    busB.req_i    = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      checkOne("t6_order", 8'(busB.gnt_idx_o), 8'(i % 5));
    end

    $display("[TB] reset during a burst");
    resetDuts(1'b0, 1'b1);
    busB.weight_i = 10'h175;
    applyStimulus(4);
    checkOne("t6_mid_burst", 8'(busB.gnt_o), 8'b00100);
    resetB = 1'b0;
    #1;
    checkOne("t6_async_clr", 8'(busB.gnt_o), 8'h00);
    checkOne("t6_async_vld", 8'(busB.gnt_valid_o), 8'h00);
    resetDuts(1'b0, 1'b1);
    applyStimulus(1);
    checkOne("t6_restart", 8'(busB.gnt_o), 8'b00001);

    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++) begin
      busA.req_i    = 4'($urandom);
      busB.req_i    = 5'($urandom);
      if ($urandom_range(0, 3) == 0) busA.weight_i = 16'($urandom);
      if ($urandom_range(0, 3) == 0) busB.weight_i = 10'($urandom);
      applyStimulus(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
